// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the split load/store unit.
//   - RISC-V func3 access codes
//   - FSM state enumeration
//   - size_of():     access size in bytes for a func3 code
//   - func3_legal(): whether a func3 code is a legal load/store for the bus width
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;   // LB  / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH  / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW  / SW
   localparam logic [2:0] F3_D  = 3'b011;   // LD  / SD  (64-bit bus only)
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU
   localparam logic [2:0] F3_WU = 3'b110;   // LWU       (64-bit bus only)

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BEAT0 = 3'd1,
      ST_BEAT1 = 3'd2,
      ST_RESP  = 3'd3,
      ST_ERR   = 3'd4
   } lsu_state_t;

   // The two low func3 bits encode log2 of the access size.
   function automatic logic [3:0] size_of(input logic [2:0] func3);
      logic [3:0] bytes;
      case (func3[1:0])
         2'b00:   bytes = 4'd1;
         2'b01:   bytes = 4'd2;
         2'b10:   bytes = 4'd4;
         default: bytes = 4'd8;
      endcase
      return bytes;
   endfunction

   // wide = 1 when the bus is 64 bits, which enables the doubleword and
   // unsigned-word encodings.
   function automatic logic func3_legal(input logic [2:0] func3,
                                        input logic       is_load,
                                        input logic       wide);
      logic ok;
      ok = 1'b0;
      if (is_load) begin
         case (func3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
            F3_D, F3_WU:                    ok = wide;
            default:                        ok = 1'b0;
         endcase
      end else begin
         case (func3)
            F3_B, F3_H, F3_W: ok = 1'b1;
            F3_D:             ok = wide;
            default:          ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

endpackage

// File: rtl/lsu_split_align.sv
// lsu_align
// Combinational data-path of the load/store unit.
//   func3     in  : access size / sign code
//   off       in  : byte offset of the access inside an NB-byte bus word
//   wdata     in  : right-aligned store data
//   rdata_lo  in  : data returned by beat0
//   rdata_hi  in  : data returned by beat1 (don't-care for single-beat accesses)
//   wdata_lo  out : store data steered onto the beat0 lanes
//   wdata_hi  out : store data steered onto the beat1 lanes
//   mask_lo   out : beat0 byte enables
//   mask_hi   out : beat1 byte enables
//   rdata_ext out : merged, right-aligned, sign/zero-extended load result
module lsu_align
   import lsu_pkg::*;
#(
   parameter  int DATA_W = 32,
   localparam int NB     = DATA_W / 8,
   localparam int OFF_W  = $clog2(NB)
) (
   input  logic [2:0]        func3,
   input  logic [OFF_W-1:0]  off,
   input  logic [DATA_W-1:0] wdata,
   input  logic [DATA_W-1:0] rdata_lo,
   input  logic [DATA_W-1:0] rdata_hi,
   output logic [DATA_W-1:0] wdata_lo,
   output logic [DATA_W-1:0] wdata_hi,
   output logic [NB-1:0]     mask_lo,
   output logic [NB-1:0]     mask_hi,
   output logic [DATA_W-1:0] rdata_ext
);

   localparam int SH_W = $clog2(DATA_W) + 1;

   logic [3:0]          size;
   logic [2*NB-1:0]     base_mask;
   logic [2*NB-1:0]     wide_mask;
   logic [2*DATA_W-1:0] wide_wdata;
   logic [2*DATA_W-1:0] merged;
   logic [DATA_W-1:0]   field;

   assign size = size_of(func3);

   // Right-aligned byte mask of `size` ones across both beats.
   for (genvar gi = 0; gi < 2 * NB; gi++) begin : g_base_mask
      assign base_mask[gi] = (gi < int'(size));
   end

   // Store steering: one double-width shift, low half feeds beat0, high half beat1.
   assign wide_wdata = {{DATA_W{1'b0}}, wdata} << {off, 3'b000};
   assign wide_mask  = base_mask << off;

   assign wdata_lo = wide_wdata[DATA_W-1:0];
   assign wdata_hi = wide_wdata[2*DATA_W-1:DATA_W];
   assign mask_lo  = wide_mask[NB-1:0];
   assign mask_hi  = wide_mask[2*NB-1:NB];

   // Load merge: bytes above `size` are discarded by the extension shifts below,
   // so stale beat1 data for single-beat loads never reaches the result.
   assign merged = {rdata_hi, rdata_lo} >> {off, 3'b000};
   assign field  = merged[DATA_W-1:0];

   logic [3:0]               keep_bytes;
   logic [SH_W-1:0]          sh;
   logic [DATA_W-1:0]        left;
   logic signed [DATA_W-1:0] left_s;

   // Extension by shifting the field to the top and back down, arithmetic
   // for signed codes (func3[2] == 0) and logical for unsigned ones.
   always_comb begin
      keep_bytes = (size > 4'(NB)) ? 4'(NB) : size;
      sh         = SH_W'(DATA_W) - SH_W'({keep_bytes, 3'b000});
      left       = field << sh;
      left_s     = $signed(left);
      if (func3[2]) begin
         rdata_ext = left >> sh;
      end else begin
         rdata_ext = left_s >>> sh;
      end
   end

endmodule

// File: rtl/lsu_split.sv
// lsu_split
// Load/store unit between the core memory stage and a variable-latency
// data-memory port. Accepts one request at a time, issues one or two aligned
// bus beats, and returns a single completion pulse.
//   clk, rst                  : clock, synchronous active-low reset
//   req_valid/req_ready       : request handshake
//   req_load/req_store        : access direction (mutually exclusive)
//   req_func3, req_addr       : access code and byte address
//   req_wdata                 : right-aligned store data
//   rsp_valid/rsp_rdata/rsp_err : one-cycle completion, extended load data, error flag
//   mem_request/mem_we/mem_addr/mem_wdata/mem_masking_byte : bus beat outputs
//   mem_valid/mem_rdata       : beat completion and read data (same cycle)
module lsu_split
   import lsu_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_load,
   input  logic                req_store,
   input  logic [2:0]          req_func3,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                mem_request,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_masking_byte,
   input  logic                mem_valid,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam bit WIDE  = (DATA_W == 64);

   lsu_state_t state_reg, state_next;

   logic              load_reg;
   logic [2:0]        func3_reg;
   logic [OFF_W-1:0]  off_reg;
   logic              misalign_reg;
   logic [DATA_W-1:0] beat0_data_reg;
   logic [DATA_W-1:0] beat1_data_reg;
   logic [ADDR_W-1:0] addr_hi_reg;
   logic [DATA_W-1:0] wdata_hi_reg;
   logic [NB-1:0]     mask_hi_reg;
   logic              mem_we_reg;
   logic [ADDR_W-1:0] mem_addr_reg;
   logic [DATA_W-1:0] mem_wdata_reg;
   logic [NB-1:0]     mem_mask_reg;

   // ------------------------------------------------------------------
   // Request decode (only meaningful in IDLE)
   // ------------------------------------------------------------------
   logic [OFF_W-1:0]  req_off;
   logic [3:0]        req_size;
   logic [4:0]        req_span;
   logic              req_misalign;
   logic              req_ok;
   logic [ADDR_W-1:0] beat0_addr;

   assign req_off      = req_addr[OFF_W-1:0];
   assign req_size     = size_of(req_func3);
   assign req_span     = 5'(req_off) + 5'(req_size);
   assign req_misalign = (req_span > 5'(NB));
   assign req_ok       = (req_load ^ req_store)
                       && func3_legal(req_func3, req_load, WIDE)
                       && (MISALIGN_EN || !req_misalign);
   assign beat0_addr   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // ------------------------------------------------------------------
   // Data path: in IDLE it steers the incoming store, afterwards it merges
   // the captured beats using the latched access code and offset.
   // ------------------------------------------------------------------
   logic              in_idle;
   logic [2:0]        al_func3;
   logic [OFF_W-1:0]  al_off;
   logic [DATA_W-1:0] al_wdata_lo;
   logic [DATA_W-1:0] al_wdata_hi;
   logic [NB-1:0]     al_mask_lo;
   logic [NB-1:0]     al_mask_hi;
   logic [DATA_W-1:0] al_rdata;

   assign in_idle  = (state_reg == ST_IDLE);
   assign al_func3 = in_idle ? req_func3 : func3_reg;
   assign al_off   = in_idle ? req_off   : off_reg;

   lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .func3     (al_func3),
      .off       (al_off),
      .wdata     (req_wdata),
      .rdata_lo  (beat0_data_reg),
      .rdata_hi  (beat1_data_reg),
      .wdata_lo  (al_wdata_lo),
      .wdata_hi  (al_wdata_hi),
      .mask_lo   (al_mask_lo),
      .mask_hi   (al_mask_hi),
      .rdata_ext (al_rdata)
   );

   // ------------------------------------------------------------------
   // FSM next state and outputs
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state_reg;
      req_ready   = 1'b0;
      mem_request = 1'b0;
      rsp_valid   = 1'b0;
      rsp_err     = 1'b0;
      rsp_rdata   = '0;
      case (state_reg)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = req_ok ? ST_BEAT0 : ST_ERR;
            end
         end
         ST_BEAT0: begin
            mem_request = 1'b1;
            if (mem_valid) begin
               state_next = misalign_reg ? ST_BEAT1 : ST_RESP;
            end
         end
         ST_BEAT1: begin
            mem_request = 1'b1;
            if (mem_valid) begin
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            rsp_valid  = 1'b1;
            rsp_rdata  = load_reg ? al_rdata : '0;
            state_next = ST_IDLE;
         end
         ST_ERR: begin
            rsp_valid  = 1'b1;
            rsp_err    = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State and data registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg      <= ST_IDLE;
         load_reg       <= 1'b0;
         func3_reg      <= '0;
         off_reg        <= '0;
         misalign_reg   <= 1'b0;
         beat0_data_reg <= '0;
         beat1_data_reg <= '0;
         addr_hi_reg    <= '0;
         wdata_hi_reg   <= '0;
         mask_hi_reg    <= '0;
         mem_we_reg     <= 1'b0;
         mem_addr_reg   <= '0;
         mem_wdata_reg  <= '0;
         mem_mask_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               // Beat0 bus fields are prepared at acceptance so they are
               // registered and stable from the first bus cycle; beat1 fields
               // wait in shadow registers.
               if (req_valid && req_ok) begin
                  load_reg      <= req_load;
                  func3_reg     <= req_func3;
                  off_reg       <= req_off;
                  misalign_reg  <= req_misalign;
                  mem_we_reg    <= req_store;
                  mem_addr_reg  <= beat0_addr;
                  addr_hi_reg   <= beat0_addr + ADDR_W'(NB);
                  mem_mask_reg  <= al_mask_lo;
                  mask_hi_reg   <= al_mask_hi;
                  mem_wdata_reg <= req_store ? al_wdata_lo : '0;
                  wdata_hi_reg  <= req_store ? al_wdata_hi : '0;
               end
            end
            ST_BEAT0: begin
               if (mem_valid) begin
                  beat0_data_reg <= mem_rdata;
                  if (misalign_reg) begin
                     mem_addr_reg  <= addr_hi_reg;
                     mem_mask_reg  <= mask_hi_reg;
                     mem_wdata_reg <= wdata_hi_reg;
                  end
               end
            end
            ST_BEAT1: begin
               if (mem_valid) begin
                  beat1_data_reg <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_we           = mem_we_reg;
   assign mem_addr         = mem_addr_reg;
   assign mem_wdata        = mem_wdata_reg;
   assign mem_masking_byte = mem_mask_reg;

endmodule
